// File: rtl/second_fsm.sv
// Two-state JK-style Moore machine: j turns the output on, k turns it off, j&k toggles.
// The output is a register written alongside the state, so it carries no path from j or k.
module second_fsm #(
  parameter int RESET_STATE = 0
) (
  input  logic clk,
  input  logic areset,
  input  logic j,
  input  logic k,
  output logic out
);

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } state_t;

  localparam state_t RST_S   = (RESET_STATE != 0) ? ON : OFF;
  localparam logic   RST_OUT = (RESET_STATE != 0);

  state_t state;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state <= RST_S;
      out   <= RST_OUT;
    end else begin
      case (state)
        OFF: begin
          if (j) begin
            state <= ON;
            out   <= 1'b1;
          end else begin
            state <= OFF;
            out   <= 1'b0;
          end
        end
        ON: begin
          if (k) begin
            state <= OFF;
            out   <= 1'b0;
          end else begin
            state <= ON;
            out   <= 1'b1;
          end
        end
        // An unknown state value falls back to OFF on the next edge.
        default: begin
          state <= OFF;
          out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_second_fsm.sv
// Bench for second_fsm: characteristic-equation model checked every falling edge,
// plus directed vectors with literal expected outputs.
module tb_second_fsm;

  bit   clk = 1'b0;
  logic areset = 1'b1;
  logic j = 1'b0;
  logic k = 1'b0;
  logic out;

  int checks = 0;
  int errors = 0;

  // Reference state: JK flip-flop characteristic equation q+ = j&~q | ~k&q.
  bit mq = 1'b0;

  second_fsm #(.RESET_STATE(0)) dut (
    .clk    (clk),
    .areset (areset),
    .j      (j),
    .k      (k),
    .out    (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge areset) begin
    if (!areset) mq = 1'b0;
    else         mq = (j & ~mq) | (~k & mq);
  end

  always @(negedge clk) begin
    checks++;
    if (out !== mq) begin
      errors++;
      $display("FAIL model_cmp t=%0t: out=%b expected=%b", $time, out, mq);
    end
  end

  task automatic chk(input string name, input logic exp);
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: out=%b expected=%b", name, $time, out, exp);
    end
  endtask

  typedef struct {
    logic j;
    logic k;
    logic exp;
  } vec_t;

  initial begin
    vec_t vecs[$];

    // Reset asserted with clk idle and both requests high.
    j = 1'b1; k = 1'b1;
    #1 areset = 1'b0;
    #1 chk("reset_immediate", 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold_edges", 1'b0);
    end

    // Release away from the rising edge, then turn on and hold.
    areset = 1'b1; j = 1'b1; k = 1'b0;
    @(negedge clk); chk("turn_on", 1'b1);
    j = 1'b0; k = 1'b0;
    @(negedge clk); chk("hold_on_1", 1'b1);
    @(negedge clk); chk("hold_on_2", 1'b1);

    // Turn off, then turn-off request while already off.
    j = 1'b0; k = 1'b1;
    @(negedge clk); chk("turn_off", 1'b0);
    @(negedge clk); chk("off_stays_off", 1'b0);

    // Toggle on j=k=1 for four edges.
    j = 1'b1; k = 1'b1;
    @(negedge clk); chk("toggle_1", 1'b1);
    @(negedge clk); chk("toggle_2", 1'b0);
    @(negedge clk); chk("toggle_3", 1'b1);
    @(negedge clk); chk("toggle_4", 1'b0);

    // Get to ON, then assert reset mid-cycle.
    j = 1'b1; k = 1'b0;
    @(negedge clk); chk("on_before_reset", 1'b1);
    #2 areset = 1'b0;
    #1 chk("async_reset_mid_on", 1'b0);
    @(posedge clk); #1 chk("edge_during_reset", 1'b0);
    @(negedge clk);
    areset = 1'b1; j = 1'b1; k = 1'b0;
    @(negedge clk); chk("on_after_release", 1'b1);

    // Wiggle j/k between rising edges; sampled values at edges are 0,0.
    j = 1'b0; k = 1'b0;
    @(posedge clk);
    #1 k = 1'b1; j = 1'b1;
    #2 k = 1'b0; j = 1'b0;
    @(negedge clk); chk("glitch_high_phase", 1'b1);
    #1 k = 1'b1;
    #2 k = 1'b0;
    #1 chk("glitch_low_phase", 1'b1);
    @(negedge clk); chk("glitch_after_edge", 1'b1);

    // Directed sequence starting from ON.
    vecs.push_back('{1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0});
    foreach (vecs[i]) begin
      j = vecs[i].j; k = vecs[i].k;
      @(negedge clk);
      chk($sformatf("vec_%0d", i), vecs[i].exp);
    end

    j = 1'b0; k = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
